// File: rtl/video_timing_gen.sv
// Programmable video timing generator: four fixed modes, sync/bp/active/fp line order.
// Optional 16-bit frame counter port when VIDEO_TIMING_GEN_FRAME_CNT_EN is defined.
module video_timing_gen #(
    parameter int X_BITS       = 12,
    parameter int Y_BITS       = 12,
    parameter int DEFAULT_MODE = 2
) (
    input  logic              pix_clk,
    input  logic              rstn,
    input  logic [1:0]        mode_sel,
    output logic              hs_out,
    output logic              vs_out,
    output logic              de_out,
    output logic [X_BITS-1:0] act_x,
    output logic [Y_BITS-1:0] act_y,
    output logic              frame_start,
    output logic [1:0]        cur_mode,
    output logic              mode_chg
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    // Counters are 12 bits regardless of X_BITS/Y_BITS: H_TOTAL reaches 2200.
    localparam int CW = 12;

    typedef struct packed {
        logic [CW-1:0] h_total;
        logic [CW-1:0] h_sync;
        logic [CW-1:0] h_bp;
        logic [CW-1:0] h_act;
        logic [CW-1:0] v_total;
        logic [CW-1:0] v_sync;
        logic [CW-1:0] v_bp;
        logic [CW-1:0] v_act;
        logic          pos_pol;
    } timing_t;

    function automatic timing_t mode_timing(input logic [1:0] m);
        timing_t t;
        case (m)
            2'd0:    t = '{12'd800,  12'd96,  12'd48,  12'd640,  12'd525,  12'd2, 12'd33, 12'd480,  1'b0};
            2'd1:    t = '{12'd1650, 12'd40,  12'd220, 12'd1280, 12'd750,  12'd5, 12'd20, 12'd720,  1'b1};
            2'd2:    t = '{12'd2200, 12'd44,  12'd148, 12'd1920, 12'd1125, 12'd5, 12'd36, 12'd1080, 1'b1};
            default: t = '{12'd1344, 12'd136, 12'd160, 12'd1024, 12'd806,  12'd6, 12'd29, 12'd768,  1'b0};
        endcase
        return t;
    endfunction

    function automatic logic mode_pos_pol(input logic [1:0] m);
        timing_t t;
        t = mode_timing(m);
        return t.pos_pol;
    endfunction

    localparam logic [1:0] DEF_MODE      = 2'(DEFAULT_MODE);
    localparam logic       DEF_SYNC_IDLE = ~mode_pos_pol(DEF_MODE);

    logic [CW-1:0]     h_cnt_q, h_cnt_d;
    logic [CW-1:0]     v_cnt_q, v_cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              de_q, de_d;
    logic [X_BITS-1:0] act_x_q, act_x_d;
    logic [Y_BITS-1:0] act_y_q, act_y_d;
    logic              fs_q, fs_d;
    logic              chg_q, chg_d;
    logic [1:0]        cur_mode_q, cur_mode_d;

    timing_t       tm;
    logic          h_last, v_last, h_in, v_in;
    logic [CW-1:0] h_start, v_start, x_off, y_off;

    always_comb begin
        tm      = mode_timing(mode_q);
        h_last  = (h_cnt_q == tm.h_total - 12'd1);
        v_last  = (v_cnt_q == tm.v_total - 12'd1);
        h_cnt_d = h_last ? '0 : h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + 12'd1;
        end
        // mode_sel is only looked at on the very last pixel of a frame.
        mode_d  = (h_last && v_last) ? mode_sel : mode_q;

        h_start = tm.h_sync + tm.h_bp;
        v_start = tm.v_sync + tm.v_bp;
        h_in    = (h_cnt_q >= h_start) && (h_cnt_q < h_start + tm.h_act);
        v_in    = (v_cnt_q >= v_start) && (v_cnt_q < v_start + tm.v_act);
        x_off   = h_cnt_q - h_start;
        y_off   = v_cnt_q - v_start;

        de_d    = h_in && v_in;
        act_x_d = de_d ? X_BITS'(x_off) : '0;
        act_y_d = de_d ? Y_BITS'(y_off) : '0;
        hs_d    = (h_cnt_q < tm.h_sync) ~^ tm.pos_pol;
        vs_d    = (v_cnt_q < tm.v_sync) ~^ tm.pos_pol;
        fs_d    = (h_cnt_q == '0) && (v_cnt_q == '0);
        // cur_mode_q still holds the previous frame's mode while state is (0,0).
        chg_d      = fs_d && (mode_q != cur_mode_q);
        cur_mode_d = mode_q;
    end

    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            mode_q     <= DEF_MODE;
            hs_q       <= DEF_SYNC_IDLE;
            vs_q       <= DEF_SYNC_IDLE;
            de_q       <= 1'b0;
            act_x_q    <= '0;
            act_y_q    <= '0;
            fs_q       <= 1'b0;
            chg_q      <= 1'b0;
            cur_mode_q <= DEF_MODE;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            mode_q     <= mode_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            de_q       <= de_d;
            act_x_q    <= act_x_d;
            act_y_q    <= act_y_d;
            fs_q       <= fs_d;
            chg_q      <= chg_d;
            cur_mode_q <= cur_mode_d;
        end
    end

    assign hs_out      = hs_q;
    assign vs_out      = vs_q;
    assign de_out      = de_q;
    assign act_x       = act_x_q;
    assign act_y       = act_y_q;
    assign frame_start = fs_q;
    assign mode_chg    = chg_q;
    assign cur_mode    = cur_mode_q;

`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Steps on the same edge that raises frame_start, so it reads 1 on the first frame.
    always_comb begin
        frame_cnt_d = fs_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen; jumps the internal counters to frame/line
// boundaries so every mode can be exercised in a few thousand cycles.
module tb_video_timing_gen;

    logic        pix_clk = 1'b0;
    logic        rstn;
    logic [1:0]  mode_sel;
    logic        hs_out, vs_out, de_out, frame_start, mode_chg;
    logic [11:0] act_x, act_y;
    logic [1:0]  cur_mode;
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    video_timing_gen #(.X_BITS(12), .Y_BITS(12), .DEFAULT_MODE(2)) dut (
        .pix_clk     (pix_clk),
        .rstn        (rstn),
        .mode_sel    (mode_sel),
        .hs_out      (hs_out),
        .vs_out      (vs_out),
        .de_out      (de_out),
        .act_x       (act_x),
        .act_y       (act_y),
        .frame_start (frame_start),
        .cur_mode    (cur_mode),
        .mode_chg    (mode_chg)
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    always #5 pix_clk = ~pix_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One active edge, then sample away from it.
    task automatic step();
        @(posedge pix_clk);
        #1;
    endtask

    logic [11:0] jh, jv;
    logic [15:0] jf;

    // Place the counters at (h, v); the next sample reflects that state.
    task jump(input int h, input int v);
        @(negedge pix_clk);
        jh = 12'(h);
        jv = 12'(v);
        force dut.h_cnt_q = jh;
        force dut.v_cnt_q = jv;
        #1;
        release dut.h_cnt_q;
        release dut.v_cnt_q;
    endtask

    task automatic wait_fs(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (n < 50) begin
            step();
            n++;
            if (frame_start === 1'b1) break;
        end
        check(tag, n, exp_cycles);
    endtask

    int hs_n, vs_n, de_n, first_x, first_y, last_x;

    // Scan n samples starting with the current one; count sync at `lvl` and de.
    task automatic count_line(input int n, input logic lvl);
        hs_n = 0; vs_n = 0; de_n = 0;
        first_x = -1; first_y = -1; last_x = -1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) step();
            if (hs_out === lvl) hs_n++;
            if (vs_out === lvl) vs_n++;
            if (de_out === 1'b1) begin
                if (de_n == 0) begin
                    first_x = int'(act_x);
                    first_y = int'(act_y);
                end
                last_x = int'(act_x);
                de_n++;
            end
        end
    endtask

    initial begin
        rstn     = 1'b0;
        mode_sel = 2'd2;
        repeat (3) @(posedge pix_clk);
        #1;
        check("rst_de", de_out, 0);
        check("rst_act_x", act_x, 0);
        check("rst_act_y", act_y, 0);
        check("rst_fs", frame_start, 0);
        check("rst_chg", mode_chg, 0);
        check("rst_cur_mode", cur_mode, 2);
        check("rst_hs_idle", hs_out, 0);
        check("rst_vs_idle", vs_out, 0);

        // Mode 2 after release.
        @(negedge pix_clk);
        rstn = 1'b1;
        step();
        check("m2_first_fs", frame_start, 1);
        check("m2_first_chg", mode_chg, 0);
        check("m2_first_vs", vs_out, 1);
        count_line(2200, 1'b1);
        check("m2_hs_width", hs_n, 44);
        check("m2_de_vblank", de_n, 0);
        step();
        check("m2_line_period_hs", hs_out, 1);
        check("m2_fs_once", frame_start, 0);

        jump(0, 41);
        step();
        count_line(2200, 1'b1);
        check("m2_de_width", de_n, 1920);
        check("m2_first_x", first_x, 0);
        check("m2_first_y", first_y, 0);
        check("m2_last_x", last_x, 1919);

        // Mid-frame switch 2 -> 1 is held off until the wrap.
        mode_sel = 2'd1;
        jump(2195, 1124);
        step();
        check("m2to1_cur_hold", cur_mode, 2);
        check("m2to1_vs_hold", vs_out, 0);
        wait_fs("m2to1_fs_latency", 5);
        check("m2to1_chg", mode_chg, 1);
        check("m2to1_cur", cur_mode, 1);
        count_line(1650, 1'b1);
        check("m1_hs_width", hs_n, 40);
        step();
        check("m1_line_period_hs", hs_out, 1);
        check("m1_chg_pulse", mode_chg, 0);

        // Mode 0, negative polarity.
        mode_sel = 2'd0;
        jump(1645, 749);
        wait_fs("m1to0_fs_latency", 6);
        check("m1to0_chg", mode_chg, 1);
        check("m1to0_cur", cur_mode, 0);
        count_line(1600, 1'b0);
        check("m0_hs_low_2lines", hs_n, 192);
        check("m0_vs_low_2lines", vs_n, 1600);
        step();
        check("m0_vs_release", vs_out, 1);

        jump(782, 514);
        step();
        check("m0_pen_x", act_x, 638);
        step();
        check("m0_last_de", de_out, 1);
        check("m0_last_x", act_x, 639);
        check("m0_last_y", act_y, 479);
        step();
        check("m0_after_de", de_out, 0);
        check("m0_after_x", act_x, 0);
        check("m0_after_y", act_y, 0);

        // Mode 3, then a 3 -> 0 -> 3 glitch inside one frame.
        mode_sel = 2'd3;
        jump(795, 524);
        wait_fs("m0to3_fs_latency", 6);
        check("m0to3_chg", mode_chg, 1);
        check("m0to3_cur", cur_mode, 3);
        count_line(1344, 1'b0);
        check("m3_hs_width", hs_n, 136);
        @(negedge pix_clk);
        mode_sel = 2'd0;
        repeat (50) step();
        @(negedge pix_clk);
        mode_sel = 2'd3;
        jump(1339, 805);
        wait_fs("m3_glitch_fs_latency", 6);
        check("m3_glitch_no_chg", mode_chg, 0);
        check("m3_glitch_cur", cur_mode, 3);

        // Reset mid active line.
        jump(500, 100);
        step();
        check("m3_mid_de", de_out, 1);
        check("m3_mid_x", act_x, 204);
        check("m3_mid_y", act_y, 65);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_de", de_out, 0);
        check("arst_x", act_x, 0);
        check("arst_y", act_y, 0);
        check("arst_hs", hs_out, 0);
        check("arst_vs", vs_out, 0);
        check("arst_cur", cur_mode, 2);
        @(negedge pix_clk);
        rstn = 1'b1;
        step();
        check("rel_fs", frame_start, 1);
        check("rel_chg", mode_chg, 0);
        check("rel_cur", cur_mode, 2);

`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
        check("fcnt_1", frame_cnt, 1);
        mode_sel = 2'd0;
        jump(2195, 1124);
        wait_fs("fcnt_fs2", 5);
        check("fcnt_2", frame_cnt, 2);
        jump(795, 524);
        wait_fs("fcnt_fs3", 6);
        check("fcnt_3", frame_cnt, 3);
        @(negedge pix_clk);
        jf = 16'hFFFF;
        force dut.frame_cnt_q = jf;
        #1;
        release dut.frame_cnt_q;
        jump(795, 524);
        wait_fs("fcnt_fs_wrap", 6);
        check("fcnt_wrap", frame_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
